// File: rtl/led_dimmer_multi.sv
// Multi-channel LED dimmer: per-channel brightness levels stepped by button pulses,
// a linear fade of each channel's duty toward its level target, and glitch-free PWM.
module led_dimmer_multi #(
   parameter  int CHANNELS = 3,
   parameter  int PWM_BITS = 7,
   parameter  int LEVELS   = 4,
   parameter  int WRAP     = 1,
   parameter  int PRESCALE = 1,
   parameter  int RAMP_DIV = 4,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int LVL_W    = $clog2(LEVELS)
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic                btn_up,
   input  logic                btn_down,
   input  logic                all_off,
   input  logic [SEL_W-1:0]    ch_sel,
   output logic [CHANNELS-1:0] pwm_out,
   output logic [LVL_W-1:0]    level_o,
   output logic                busy
);

   localparam logic [PWM_BITS-1:0] MAXD    = {PWM_BITS{1'b1}};
   localparam logic [LVL_W-1:0]    TOP_LVL = LVL_W'(LEVELS - 1);
   localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int                  RD_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [RD_W-1:0]     RD_LAST = RD_W'(RAMP_DIV - 1);

   function automatic logic [LEVELS*PWM_BITS-1:0] build_targets();
      logic [LEVELS*PWM_BITS-1:0] tbl;
      tbl = '0;
      for (int l = 0; l < LEVELS; l++) begin
         tbl[l*PWM_BITS +: PWM_BITS] = PWM_BITS'((l * int'(MAXD)) / (LEVELS - 1));
      end
      return tbl;
   endfunction

   // Level-to-duty lookup, fixed at elaboration so no divider is built.
   localparam logic [LEVELS*PWM_BITS-1:0] TARGETS = build_targets();

   logic [LVL_W-1:0]    level_r     [CHANNELS];
   logic [LVL_W-1:0]    level_nxt_s [CHANNELS];
   logic [PWM_BITS-1:0] target_s    [CHANNELS];
   logic [PWM_BITS-1:0] cur_r       [CHANNELS];
   logic [PWM_BITS-1:0] applied_r   [CHANNELS];
   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [PS_W-1:0]     ps_cnt_r;
   logic [RD_W-1:0]     ramp_cnt_r;
   logic [CHANNELS-1:0] pwm_r;
   logic                busy_r;
   logic                ramp_tick_s;
   logic                cnt_step_s;
   logic                period_wrap_s;
   logic                busy_s;
   logic [LVL_W-1:0]    level_sel_s;

   // Next level per channel: all_off wins, opposing pulses cancel, bad ch_sel matches nothing.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         level_nxt_s[i] = level_r[i];
         if (all_off) begin
            level_nxt_s[i] = '0;
         end else if ((btn_up != btn_down) && (ch_sel == SEL_W'(i))) begin
            if (btn_up) begin
               if (level_r[i] != TOP_LVL) begin
                  level_nxt_s[i] = level_r[i] + LVL_W'(1'b1);
               end else if (WRAP != 0) begin
                  level_nxt_s[i] = '0;
               end else begin
                  level_nxt_s[i] = TOP_LVL;
               end
            end else begin
               if (level_r[i] != '0) begin
                  level_nxt_s[i] = level_r[i] - LVL_W'(1'b1);
               end else if (WRAP != 0) begin
                  level_nxt_s[i] = TOP_LVL;
               end else begin
                  level_nxt_s[i] = '0;
               end
            end
         end else begin
            level_nxt_s[i] = level_r[i];
         end
      end
   end

   // Timebase strobes, per-channel targets, busy term and the selected-level read.
   always_comb begin
      ramp_tick_s   = (ramp_cnt_r == RD_LAST);
      cnt_step_s    = (ps_cnt_r == PS_LAST);
      period_wrap_s = cnt_step_s && (pwm_cnt_r == MAXD);
      busy_s        = 1'b0;
      level_sel_s   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         target_s[i] = TARGETS[int'(level_r[i]) * PWM_BITS +: PWM_BITS];
         busy_s      = busy_s | (cur_r[i] != target_s[i]);
         level_sel_s = level_sel_s | ((ch_sel == SEL_W'(i)) ? level_r[i] : '0);
      end
   end

   // Shared timebase: ramp divider, PWM prescaler and free-running PWM counter.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         ramp_cnt_r <= '0;
         ps_cnt_r   <= '0;
         pwm_cnt_r  <= '0;
      end else begin
         ramp_cnt_r <= ramp_tick_s ? '0 : ramp_cnt_r + RD_W'(1'b1);
         ps_cnt_r   <= cnt_step_s ? '0 : ps_cnt_r + PS_W'(1'b1);
         if (cnt_step_s) begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
         end
      end
   end

   // Per-channel level, 1-LSB fade toward target, and duty latched only at the period boundary.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         for (int i = 0; i < CHANNELS; i++) begin
            level_r[i]   <= '0;
            cur_r[i]     <= '0;
            applied_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            level_r[i] <= level_nxt_s[i];
            if (ramp_tick_s && (cur_r[i] < target_s[i])) begin
               cur_r[i] <= cur_r[i] + PWM_BITS'(1'b1);
            end else if (ramp_tick_s && (cur_r[i] > target_s[i])) begin
               cur_r[i] <= cur_r[i] - PWM_BITS'(1'b1);
            end
            if (period_wrap_s) begin
               applied_r[i] <= cur_r[i];
            end
         end
      end
   end

   // Registered compare; full scale is forced solid high so it never drops at cnt == MAXD.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         pwm_r  <= '0;
         busy_r <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_r[i] <= (applied_r[i] == MAXD) ? 1'b1 : (pwm_cnt_r < applied_r[i]);
         end
         busy_r <= busy_s;
      end
   end

   assign pwm_out = pwm_r;
   assign busy    = busy_r;
   assign level_o = level_sel_s;

endmodule

// File: tb/tb_led_dimmer_multi.sv
// Bench for led_dimmer_multi: two instances (wrap/prescale 1, saturate/prescale 3)
// checked against a time-indexed behavioural reference.
module tb_led_dimmer_multi;
   localparam int CH   = 3;
   localparam int LV   = 4;
   localparam int RD   = 4;
   localparam int MAXD = 127;

   logic       clk      = 1'b0;
   logic       reset_p  = 1'b0;
   logic       btn_up   = 1'b0;
   logic       btn_down = 1'b0;
   logic       all_off  = 1'b0;
   logic [1:0] ch_sel   = 2'd0;
   logic [2:0] pwm_a, pwm_b;
   logic       busy_a, busy_b;
   logic [1:0] lvl_a, lvl_b;
   wire [11:0] obs = {pwm_a, busy_a, lvl_a, pwm_b, busy_b, lvl_b};

   int vecs = 0;
   int errs = 0;
   int m_k;
   int m_lvl [2][CH];
   int m_cur [2][CH];
   int m_app [2][CH];
   bit m_out [2][CH];
   bit m_busy [2];
   int wrap_p [2] = '{1, 0};
   int pre_p  [2] = '{1, 3};

   always #5 clk = ~clk;

   led_dimmer_multi #(.CHANNELS(3), .PWM_BITS(7), .LEVELS(4), .WRAP(1), .PRESCALE(1), .RAMP_DIV(4)) dut_a (
      .clk(clk), .reset_p(reset_p), .btn_up(btn_up), .btn_down(btn_down), .all_off(all_off),
      .ch_sel(ch_sel), .pwm_out(pwm_a), .level_o(lvl_a), .busy(busy_a));

   led_dimmer_multi #(.CHANNELS(3), .PWM_BITS(7), .LEVELS(4), .WRAP(0), .PRESCALE(3), .RAMP_DIV(4)) dut_b (
      .clk(clk), .reset_p(reset_p), .btn_up(btn_up), .btn_down(btn_down), .all_off(all_off),
      .ch_sel(ch_sel), .pwm_out(pwm_b), .level_o(lvl_b), .busy(busy_b));

   function automatic int tgt(int l);
      return (l * MAXD) / (LV - 1);
   endfunction

   task automatic model_reset();
      m_k = 0;
      for (int j = 0; j < 2; j++) begin
         m_busy[j] = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_lvl[j][i] = 0;
            m_cur[j][i] = 0;
            m_app[j][i] = 0;
            m_out[j][i] = 1'b0;
         end
      end
   endtask

   // m_k counts clocks since reset release; counter, tick and period boundary derive from it.
   task automatic cyc();
      int nl, nc, na, cnt, t;
      bit nb;
      for (int j = 0; j < 2; j++) begin
         cnt = (m_k / pre_p[j]) % (MAXD + 1);
         nb  = 1'b0;
         for (int i = 0; i < CH; i++) begin
            t = tgt(m_lvl[j][i]);
            if (m_cur[j][i] != t) nb = 1'b1;
            m_out[j][i] = (m_app[j][i] == MAXD) || (cnt < m_app[j][i]);
            na = (((m_k + 1) % ((MAXD + 1) * pre_p[j])) == 0) ? m_cur[j][i] : m_app[j][i];
            nc = m_cur[j][i];
            if (((m_k + 1) % RD) == 0) begin
               if (nc < t) nc++;
               else if (nc > t) nc--;
            end
            nl = m_lvl[j][i];
            if (all_off) nl = 0;
            else if ((btn_up != btn_down) && (int'(ch_sel) == i)) begin
               if (btn_up) nl = (nl == LV - 1) ? (wrap_p[j] != 0 ? 0 : LV - 1) : nl + 1;
               else        nl = (nl == 0) ? (wrap_p[j] != 0 ? LV - 1 : 0) : nl - 1;
            end
            m_lvl[j][i] = nl;
            m_cur[j][i] = nc;
            m_app[j][i] = na;
         end
         m_busy[j] = nb;
      end
      m_k++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] expv();
      logic [5:0] h [2];
      int lv;
      for (int j = 0; j < 2; j++) begin
         lv = 0;
         if (int'(ch_sel) < CH) lv = m_lvl[j][ch_sel];
         h[j] = {m_out[j][2], m_out[j][1], m_out[j][0], m_busy[j], 2'(lv)};
      end
      return {h[0], h[1]};
   endfunction

   task automatic press(input logic up, input logic dn, input logic off, input logic [1:0] sel);
      btn_up = up; btn_down = dn; all_off = off; ch_sel = sel;
      cyc();
      btn_up = 1'b0; btn_down = 1'b0; all_off = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset_p = 1'b1;
      model_reset();
      @(posedge clk);
      #3;
      reset_p = 1'b0;
   endtask

   task automatic test_reset();
      int highs;
      #2;
      reset_p = 1'b1;
      ch_sel  = 2'd0;
      #1;
      vecs++;
      if (obs !== 12'd0) begin
         errs++; $display("FAIL reset_async got=%b exp=%b", obs, 12'd0);
      end
      model_reset();
      @(posedge clk);
      #3;
      reset_p = 1'b0;
      highs = 0;
      for (int n = 0; n < 300; n++) begin
         cyc(); vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL reset_idle k=%0d got=%b exp=%b", m_k, obs, expv());
         end
         if ((pwm_a != 3'd0) || (pwm_b != 3'd0)) highs++;
      end
      vecs++;
      if (highs !== 0) begin
         errs++; $display("FAIL reset_pwm_quiet got=%0d high cycles exp=0", highs);
      end
   endtask

   task automatic test_ramp_up();
      int highs, other, n;
      do_reset();
      cyc(); cyc();
      press(1'b1, 1'b0, 1'b0, 2'd0);
      vecs++;
      if (lvl_a !== 2'd1) begin
         errs++; $display("FAIL ramp_level got=%0d exp=1", lvl_a);
      end
      cyc(); vecs++;
      if (busy_a !== 1'b1) begin
         errs++; $display("FAIL ramp_busy got=%b exp=1", busy_a);
      end
      n = 0;
      while (!(m_k >= 256 && (m_k % 128) == 0) && n < 1000) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL ramp_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      highs = 0; other = 0;
      for (int c = 0; c < 128; c++) begin
         cyc(); vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL ramp_period k=%0d got=%b exp=%b", m_k, obs, expv());
         end
         if (pwm_a[0]) highs++;
         if (pwm_a[2:1] != 2'd0) other++;
      end
      vecs++;
      if (highs !== 42 || other !== 0 || busy_a !== 1'b0) begin
         errs++; $display("FAIL ramp_duty got=%0d/%0d/%b exp=42/0/0", highs, other, busy_a);
      end
   endtask

   task automatic test_wrap();
      int exp_a [4] = '{1, 2, 3, 0};
      int exp_b [4] = '{1, 2, 3, 3};
      do_reset();
      for (int p = 0; p < 4; p++) begin
         press(1'b1, 1'b0, 1'b0, 2'd1);
         vecs++;
         if (lvl_a !== 2'(exp_a[p]) || lvl_b !== 2'(exp_b[p]) || obs !== expv()) begin
            errs++; $display("FAIL wrap_up%0d got=%0d/%0d exp=%0d/%0d", p, lvl_a, lvl_b, exp_a[p], exp_b[p]);
         end
         cyc();
      end
      press(1'b0, 1'b1, 1'b0, 2'd2);
      vecs++;
      if (lvl_a !== 2'd3 || lvl_b !== 2'd0 || obs !== expv()) begin
         errs++; $display("FAIL wrap_down got=%0d/%0d exp=3/0", lvl_a, lvl_b);
      end
      for (int n = 0; n < 100; n++) begin
         cyc(); vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL wrap_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
   endtask

   task automatic test_full_scale();
      int ha, hb, n;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         press(1'b1, 1'b0, 1'b0, 2'd2);
         cyc();
      end
      n = 0;
      while (!(m_k >= 640 && (m_k % 128) == 0) && n < 2000) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL full_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      ha = 0;
      for (int c = 0; c < 384; c++) begin
         cyc();
         if (pwm_a[2]) ha++;
      end
      vecs++;
      if (ha !== 384) begin
         errs++; $display("FAIL full_solid got=%0d exp=384", ha);
      end
      press(1'b0, 1'b1, 1'b0, 2'd2);
      n = 0;
      while (!(m_k >= 1536 && (m_k % 384) == 0) && n < 2000) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL full_down_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      ha = 0; hb = 0;
      for (int c = 0; c < 384; c++) begin
         cyc();
         if (pwm_a[2]) ha++;
         if (pwm_b[2]) hb++;
      end
      vecs++;
      if (ha !== 252 || hb !== 252) begin
         errs++; $display("FAIL full_step_down got=%0d/%0d exp=252/252", ha, hb);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      do_reset();
      press(1'b1, 1'b0, 1'b0, 2'd0);
      cyc();
      press(1'b1, 1'b1, 1'b0, 2'd0);
      vecs++;
      if (lvl_a !== 2'd1 || obs !== expv()) begin
         errs++; $display("FAIL simul_updown got=%0d exp=1", lvl_a);
      end
      press(1'b1, 1'b0, 1'b0, 2'd1);
      for (int c = 0; c < 40; c++) cyc();
      press(1'b1, 1'b0, 1'b1, 2'd1);
      vecs++;
      if (lvl_a !== 2'd0 || lvl_b !== 2'd0 || obs !== expv()) begin
         errs++; $display("FAIL simul_alloff got=%0d/%0d exp=0/0", lvl_a, lvl_b);
      end
      ch_sel = 2'd0;
      #1;
      vecs++;
      if (lvl_a !== 2'd0) begin
         errs++; $display("FAIL simul_alloff_ch0 got=%0d exp=0", lvl_a);
      end
      n = 0;
      while ((busy_a || busy_b) && n < 500) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL simul_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      vecs++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errs++; $display("FAIL simul_busy_drop got=%b/%b exp=0/0", busy_a, busy_b);
      end
   endtask

   task automatic test_glitch();
      int highs, n;
      do_reset();
      press(1'b1, 1'b0, 1'b0, 2'd0);
      n = 0;
      while (!(m_app[0][0] == 42 && (m_k % 128) == 40) && n < 1000) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL glitch_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      press(1'b1, 1'b0, 1'b0, 2'd0);
      highs = pwm_a[0] ? 1 : 0;
      n = 0;
      while ((m_k % 128) != 0 && n < 200) begin
         cyc(); n++; vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL glitch_tail_trace k=%0d got=%b exp=%b", m_k, obs, expv());
         end
         if (pwm_a[0]) highs++;
      end
      vecs++;
      if (highs !== 2) begin
         errs++; $display("FAIL glitch_tail got=%0d high exp=2", highs);
      end
      cyc(); vecs++;
      if (pwm_a[0] !== 1'b1 || obs !== expv()) begin
         errs++; $display("FAIL glitch_new_period got=%b exp=1", pwm_a[0]);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         r        = int'($urandom_range(0, 99));
         btn_up   = (r < 8) || (r == 98);
         btn_down = (r >= 8 && r < 16) || (r == 98);
         all_off  = (r == 97);
         ch_sel   = 2'($urandom_range(0, 3));
         cyc(); vecs++;
         if (obs !== expv()) begin
            errs++; $display("FAIL random k=%0d got=%b exp=%b", m_k, obs, expv());
         end
      end
      btn_up = 1'b0; btn_down = 1'b0; all_off = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_wrap();
      test_full_scale();
      test_simultaneous();
      test_glitch();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
